// File: rtl/zbt_pkg.sv
// Shared ZBT definitions for the point table, the loader and the display reader.
// Holds the loader state encoding, the bus widths and the point word field layout.
package zbt_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;

    // Point word layout: {6'b0, x[9:0], y[9:0], color[9:0]}
    localparam int X_LSB     = 20;
    localparam int Y_LSB     = 10;
    localparam int COLOR_LSB = 0;
    localparam int FIELD_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    function automatic logic [ZBT_DATA_W-1:0] pack_point(
        input logic [FIELD_W-1:0] x,
        input logic [FIELD_W-1:0] y,
        input logic [FIELD_W-1:0] color
    );
        logic [ZBT_DATA_W-1:0] w;
        w = '0;
        w[X_LSB +: FIELD_W]     = x;
        w[Y_LSB +: FIELD_W]     = y;
        w[COLOR_LSB +: FIELD_W] = color;
        return w;
    endfunction

endpackage

// File: rtl/zbt_point_loader.sv
// Copies a fixed point table into ZBT SRAM, one granted write per point.
// The table itself sits beside this block; only its index/value pair crosses the boundary.
module zbt_point_loader
    import zbt_pkg::*;
#(
    parameter int                 NUM_POINTS = 4,
    parameter int                 IDX_W      = 2,
    parameter int                 ADDR_W     = ZBT_ADDR_W,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [IDX_W-1:0]      index,
    input  logic [ZBT_DATA_W-1:0] value,
    input  logic                  mem_grant,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [ZBT_DATA_W-1:0] mem_write_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    load_state_e           state_q;
    logic [IDX_W-1:0]      index_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W-1:0]     addr_d;
    logic [ZBT_DATA_W-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;

    // Modulo ADDR_W: a base near the top of memory wraps silently to 0.
    assign addr_d = BASE_ADDR + ADDR_W'(index_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        index_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    data_q  <= value;
                    addr_q  <= addr_d;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    // Leaving WRITE on the grant cycle guarantees a single strobe per point.
                    if (mem_grant) begin
                        if (index_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            index_q <= index_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the strobe lands in the grant cycle itself.
    assign mem_we         = (state_q == ST_WRITE) & mem_grant;
    assign index          = index_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = data_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_zbt_point_loader.sv
// Bench for zbt_point_loader: two instances (base 0 and base 7FFFE) share stimulus and
// are checked every cycle against a cycle-arithmetic model, plus literal write/done timing.
module tb_zbt_point_loader;

    localparam int          N      = 4;
    localparam logic [18:0] BASE_B = 19'h7FFFE;

    logic        clk = 1'b0;
    logic        reset, start, grant;
    logic [1:0]  index_a, index_b;
    logic [35:0] value_a, value_b, wdata_a, wdata_b;
    logic [18:0] addr_a, addr_b;
    logic        we_a, we_b, busy_a, busy_b, done_a, done_b;

    logic [35:0] tbl    [N];
    logic [35:0] deftbl [N];
    logic [18:0] exp_b_addr [N];

    assign value_a = tbl[index_a];
    assign value_b = tbl[index_b];

    zbt_point_loader #(.NUM_POINTS(N), .IDX_W(2), .ADDR_W(19), .BASE_ADDR(19'd0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .index(index_a), .value(value_a),
        .mem_grant(grant), .mem_we(we_a), .mem_addr(addr_a), .mem_write_data(wdata_a),
        .busy(busy_a), .done(done_a));

    zbt_point_loader #(.NUM_POINTS(N), .IDX_W(2), .ADDR_W(19), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .reset(reset), .start(start), .index(index_b), .value(value_b),
        .mem_grant(grant), .mem_we(we_b), .mem_addr(addr_b), .mem_write_data(wdata_b),
        .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc - t0, act, exp);
        end
    endtask

    typedef struct {
        int          c;
        logic [18:0] a;
        logic [35:0] d;
    } wr_t;
    wr_t wlog_a[$];
    wr_t wlog_b[$];
    int  dlog_a[$];
    bit  bh [256];

    // Model: a load accepted in cycle s makes point 0 writable from s+2; point i is
    // written at the first granted cycle >= its eligible cycle, the next point becomes
    // eligible two cycles later, done follows the last write by one cycle.
    bit          m_act     [2];
    int          m_p       [2];
    int          m_elig    [2];
    int          m_done_at [2];
    logic [1:0]  m_idx     [2];
    logic [18:0] m_addr    [2];
    logic [35:0] m_data    [2];

    function automatic logic [18:0] base_of(input int d);
        return (d == 0) ? 19'd0 : BASE_B;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d]     = 1'b0;
                m_p[d]       = 0;
                m_elig[d]    = 0;
                m_done_at[d] = -1;
                m_idx[d]     = 2'd0;
                m_addr[d]    = base_of(d);
                m_data[d]    = 36'd0;
            end
        end else begin
            if (we_a) wlog_a.push_back('{cyc - t0, addr_a, wdata_a});
            if (we_b) wlog_b.push_back('{cyc - t0, addr_b, wdata_b});
            if (done_a) dlog_a.push_back(cyc - t0);
            if (cyc - t0 >= 0 && cyc - t0 < 256) bh[cyc - t0] = busy_a;
            for (int d = 0; d < 2; d++) begin
                bit          in_write, is_done, e_we;
                logic [1:0]  a_idx;
                logic [18:0] a_addr;
                logic [35:0] a_data;
                logic        a_we, a_busy, a_done;
                a_idx  = (d == 0) ? index_a : index_b;
                a_addr = (d == 0) ? addr_a  : addr_b;
                a_data = (d == 0) ? wdata_a : wdata_b;
                a_we   = (d == 0) ? we_a    : we_b;
                a_busy = (d == 0) ? busy_a  : busy_b;
                a_done = (d == 0) ? done_a  : done_b;
                in_write = m_act[d] && (cyc >= m_elig[d]);
                is_done  = (cyc == m_done_at[d]);
                if (in_write) begin
                    m_addr[d] = base_of(d) + 19'(m_p[d]);
                    m_data[d] = tbl[m_p[d]];
                end
                e_we = in_write && grant;
                chk(d == 0 ? "we_a" : "we_b", a_we, e_we);
                chk(d == 0 ? "busy_a" : "busy_b", a_busy, m_act[d] || is_done);
                chk(d == 0 ? "done_a" : "done_b", a_done, is_done);
                chk(d == 0 ? "index_a" : "index_b", a_idx, m_idx[d]);
                chk(d == 0 ? "addr_a" : "addr_b", a_addr, m_addr[d]);
                chk(d == 0 ? "data_a" : "data_b", a_data, m_data[d]);
                if (e_we) begin
                    if (m_p[d] == N - 1) begin
                        m_act[d]     = 1'b0;
                        m_done_at[d] = cyc + 1;
                    end else begin
                        m_p[d]    = m_p[d] + 1;
                        m_elig[d] = cyc + 2;
                    end
                    m_idx[d] = 2'(m_p[d]);
                end else if (!m_act[d] && !is_done && start) begin
                    m_act[d]  = 1'b1;
                    m_p[d]    = 0;
                    m_idx[d]  = 2'd0;
                    m_elig[d] = cyc + 2;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        t0 = cyc;
        wlog_a.delete();
        wlog_b.delete();
        dlog_a.delete();
        for (int i = 0; i < 256; i++) bh[i] = 1'b0;
    endtask

    // gmode: 0 grant high, 1 low at 2,5,8,11.., 2 low for cycles 2..21, 3 random
    task automatic run(input int len, input int gmode, input int s0, input int s1,
                       input int s2, input int s3);
        clear_logs();
        for (int r = 0; r < len; r++) begin
            start = (r == s0) || (r == s1) || (r == s2) || (r == s3);
            case (gmode)
                0:       grant = 1'b1;
                1:       grant = ((r - 2) % 3) != 0;
                2:       grant = !(r >= 2 && r < 22);
                default: grant = ($urandom_range(0, 3) != 0);
            endcase
            step();
        end
        start = 1'b0;
    endtask

    task automatic check_log(input string tag, input int c0, input int c1, input int c2, input int c3);
        int cs [N];
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        chk({tag, "_nwr_a"}, wlog_a.size(), N);
        chk({tag, "_nwr_b"}, wlog_b.size(), N);
        if (wlog_a.size() == N && wlog_b.size() == N) begin
            for (int i = 0; i < N; i++) begin
                chk({tag, "_wcyc"}, wlog_a[i].c, cs[i]);
                chk({tag, "_waddr"}, wlog_a[i].a, 19'(i));
                chk({tag, "_wdata"}, wlog_a[i].d, deftbl[i]);
                chk({tag, "_waddr_b"}, wlog_b[i].a, exp_b_addr[i]);
            end
        end
    endtask

    task automatic reset_mid(input int rc, input logic we_before);
        clear_logs();
        grant = 1'b1;
        for (int r = 0; r < rc; r++) begin
            start = (r == 0);
            step();
        end
        start = 1'b0;
        chk("pre_rst_we", we_a, we_before);
        chk("pre_rst_busy", busy_a, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_we_a", we_a, 1'b0);
        chk("rst_we_b", we_b, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_busy_b", busy_b, 1'b0);
        step();
        step();
        reset = 1'b0;
        chk("rst_partial_writes", wlog_a.size(), 2);
        chk("rst_no_done", dlog_a.size(), 0);
        run(12, 0, 0, -1, -1, -1);
        check_log("reload", 2, 4, 6, 8);
    endtask

    initial begin
        deftbl[0] = {6'd0, 10'd300, 10'd300, 10'b1111111100};
        deftbl[1] = {6'd0, 10'd300, 10'd300, 10'b0011111100};
        deftbl[2] = {6'd0, 10'd500, 10'd500, 10'b0011111100};
        deftbl[3] = {6'd0, 10'd400, 10'd400, 10'b0111111100};
        exp_b_addr[0] = 19'h7FFFE;
        exp_b_addr[1] = 19'h7FFFF;
        exp_b_addr[2] = 19'h00000;
        exp_b_addr[3] = 19'h00001;
        for (int i = 0; i < N; i++) tbl[i] = deftbl[i];
        reset = 1'b1;
        start = 1'b0;
        grant = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("reset_index", index_a, 2'd0);
        chk("reset_addr_a", addr_a, 19'd0);
        chk("reset_addr_b", addr_b, 19'h7FFFE);
        chk("reset_data", wdata_a, 36'd0);
        chk("reset_busy", busy_a, 1'b0);
        chk("reset_done", done_a, 1'b0);
        chk("reset_we", we_a, 1'b0);

        // Grant always high
        run(12, 0, 0, -1, -1, -1);
        check_log("basic", 2, 4, 6, 8);
        chk("basic_ndone", dlog_a.size(), 1);
        if (dlog_a.size() > 0) chk("basic_done_cyc", dlog_a[0], 9);
        chk("basic_busy_c1", bh[1], 1'b1);
        chk("basic_busy_c9", bh[9], 1'b1);
        chk("basic_busy_c10", bh[10], 1'b0);

        // One stall cycle per write
        run(16, 1, 0, -1, -1, -1);
        check_log("alt", 3, 6, 9, 12);
        chk("alt_ndone", dlog_a.size(), 1);
        if (dlog_a.size() > 0) chk("alt_done_cyc", dlog_a[0], 13);

        // Long stall in the first WRITE
        run(32, 2, 0, -1, -1, -1);
        check_log("stall", 22, 24, 26, 28);
        if (dlog_a.size() > 0) chk("stall_done_cyc", dlog_a[0], 29);

        // Starts while busy and in DONE are dropped; start the cycle after is taken
        run(24, 0, 0, 3, 9, 10);
        chk("restart_nwr", wlog_a.size(), 2 * N);
        if (wlog_a.size() == 2 * N) begin
            chk("restart_w4_cyc", wlog_a[4].c, 12);
            chk("restart_w4_addr", wlog_a[4].a, 19'd0);
            chk("restart_w7_cyc", wlog_a[7].c, 18);
            chk("restart_w7_data", wlog_a[7].d, deftbl[3]);
        end
        chk("restart_ndone", dlog_a.size(), 2);
        if (dlog_a.size() == 2) chk("restart_done2", dlog_a[1], 19);

        reset_mid(5, 1'b0);
        reset_mid(6, 1'b1);

        // Randomized tables, grants and stray starts
        for (int k = 0; k < 20; k++) begin
            int ok;
            for (int i = 0; i < N; i++) tbl[i] = {4'($urandom), $urandom};
            run(60, 3, 0, $urandom_range(1, 59), $urandom_range(1, 59), -1);
            ok = 0;
            for (int w = 0; w < 200; w++) begin
                if (!busy_a && !busy_b) begin
                    ok = 1;
                    break;
                end
                grant = 1'b1;
                step();
            end
            chk("rand_idle_timeout", ok, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
